mine_field_gen: RTL and testbench

//  Upstream stage of the game controller: on initcue, places MINES mines on a 16x16 board

---
 rtl/minesweeper_pkg.sv | 9 +
 rtl/mine_field_gen_if.sv | 26 ++
 rtl/mine_lfsr.sv | 18 +
 rtl/mine_field_gen.sv | 144 ++++++++++++++
 tb/tb_mine_field_gen.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/minesweeper_pkg.sv
// Shared minesweeper types and board geometry, used by the generator, controller and display stages.
package minesweeper_pkg;
  localparam int GRID_W = 16;
  localparam int GRID_H = 16;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, READY} gen_state_t;
endpackage

// File: rtl/mine_field_gen_if.sv
// Controller <-> mine field generator bus. Optional macro SAFE_FIRST_EN adds the safe_addr signal.
interface mine_field_gen_if;
  import minesweeper_pkg::*;

  logic              initcue;
  logic              q_req;
  logic [ADDR_W-1:0] A;
  logic              valid;
  logic              is_mine;
  logic [CNT_W-1:0]  mine_cnt;
  logic              status;
  logic [ADDR_W-1:0] placed;
`ifdef SAFE_FIRST_EN
  logic [ADDR_W-1:0] safe_addr;

  modport master (output initcue, q_req, A, safe_addr,
                  input  valid, is_mine, mine_cnt, status, placed);
  modport slave  (input  initcue, q_req, A, safe_addr,
                  output valid, is_mine, mine_cnt, status, placed);
`else
  modport master (output initcue, q_req, A,
                  input  valid, is_mine, mine_cnt, status, placed);
  modport slave  (input  initcue, q_req, A,
                  output valid, is_mine, mine_cnt, status, placed);
`endif
endinterface

// File: rtl/mine_lfsr.sv
// 9-bit Fibonacci LFSR, polynomial x^9+x^5+1 (maximal length, 511 states).
module mine_lfsr #(
  parameter logic [8:0] SEED = 9'h1A5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  output logic [8:0] o_state
);
  logic [8:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_state <= SEED;
    else if (i_en) r_state <= {r_state[7:0], r_state[8] ^ r_state[4]};
  end

  assign o_state = r_state;
endmodule

// File: rtl/mine_field_gen.sv
// Places MINES mines on a 16x16 board from a free-running LFSR and answers is_mine / neighbour-count queries.
// Optional macro SAFE_FIRST_EN: the cell on safe_addr (sampled at initcue rise) is never mined.
module mine_field_gen
  import minesweeper_pkg::*;
#(
  parameter int         MINES     = 40,
  parameter logic [8:0] LFSR_SEED = 9'h1A5
) (
  input  logic               clk,
  input  logic               rst_n,
  mine_field_gen_if.slave    bus
);
  localparam logic [ADDR_W-1:0] L_MINES = ADDR_W'(MINES);

  if (MINES < 1 || MINES > 255) begin : g_bad_mines
    $error("mine_field_gen: MINES must be within 1..255");
  end
  if (LFSR_SEED == 9'h000) begin : g_bad_seed
    $error("mine_field_gen: LFSR_SEED must be nonzero");
  end
`ifdef SAFE_FIRST_EN
  if (MINES > 254) begin : g_bad_safe
    $error("mine_field_gen: MINES must be <= 254 when a safe cell is reserved");
  end
`endif

  gen_state_t                   r_state, w_state_nxt;
  logic                         r_initcue_d;
  logic [GRID_W*GRID_H-1:0]     r_bitmap;
  logic [ADDR_W-1:0]            r_placed;
  logic                         r_status;
  logic                         r_valid;
  logic                         r_is_mine;
  logic [CNT_W-1:0]             r_cnt;
  logic [8:0]                   w_lfsr;
  logic                         w_unused_lfsr_msb;
  logic [ADDR_W-1:0]            w_cand;
  logic                         w_rise;
  logic                         w_free;
  logic                         w_place;

  mine_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (1'b1),
    .o_state (w_lfsr)
  );

  assign w_cand            = w_lfsr[ADDR_W-1:0];
  assign w_unused_lfsr_msb = w_lfsr[8];
  assign w_rise            = bus.initcue & ~r_initcue_d;

`ifdef SAFE_FIRST_EN
  logic [ADDR_W-1:0] r_safe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_safe <= '0;
    else if (w_rise) r_safe <= bus.safe_addr;
  end

  assign w_free = ~r_bitmap[w_cand] & (w_cand != r_safe);
`else
  assign w_free = ~r_bitmap[w_cand];
`endif

  // Cells off the board contribute nothing: the grid does not wrap.
  function automatic logic [CNT_W-1:0] neighbour_count(input logic [GRID_W*GRID_H-1:0] bm,
                                                       input logic [ADDR_W-1:0]        a);
    logic [CNT_W-1:0]  sum;
    logic [ADDR_W-1:0] idx;
    int                nx, ny;
    sum = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(a[3:0]) + dx;
        ny = int'(a[7:4]) + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H) begin
          idx = ADDR_W'(ny * GRID_W + nx);
          sum = sum + CNT_W'(bm[idx]);
        end
      end
    end
    return sum;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_place     = 1'b0;
    unique case (r_state)
      IDLE:  if (w_rise) w_state_nxt = CLEAR;
      CLEAR: w_state_nxt = PLACE;
      PLACE: begin
        if (w_rise)                    w_state_nxt = CLEAR;
        else if (r_placed == L_MINES)  w_state_nxt = READY;
        else                           w_place     = w_free;
      end
      READY: if (w_rise) w_state_nxt = CLEAR;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_initcue_d <= 1'b0;
      r_bitmap    <= '0;
      r_placed    <= '0;
      r_status    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_initcue_d <= bus.initcue;
      if (r_state == CLEAR) begin
        r_bitmap <= '0;
        r_placed <= '0;
        r_status <= 1'b0;
      end else if (w_place) begin
        r_bitmap[w_cand] <= 1'b1;
        r_placed         <= r_placed + 8'd1;
      end
      if (r_state == PLACE && w_state_nxt == READY) r_status <= 1'b1;
    end
  end

  // Queries read the bitmap as it stood before this edge, so a query during CLEAR sees the old board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_is_mine <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_valid <= bus.q_req;
      if (bus.q_req) begin
        r_is_mine <= r_status & r_bitmap[bus.A];
        r_cnt     <= r_status ? neighbour_count(r_bitmap, bus.A) : '0;
      end
    end
  end

  assign bus.valid    = r_valid;
  assign bus.is_mine  = r_is_mine;
  assign bus.mine_cnt = r_cnt;
  assign bus.status   = r_status;
  assign bus.placed   = r_placed;
endmodule

// File: tb/tb_mine_field_gen.sv
// Directed self-checking bench for mine_field_gen; SAFE_FIRST_EN builds exercise the safe-cell variant.
module tb_mine_field_gen;
  import minesweeper_pkg::*;

`ifdef SAFE_FIRST_EN
  localparam int MINES = 254;
`else
  localparam int MINES = 40;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] tb_bm;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  mine_field_gen_if bus();

  mine_field_gen #(.MINES(MINES), .LFSR_SEED(9'h1A5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic query(input logic [7:0] a);
    @(negedge clk);
    bus.q_req = 1'b1;
    bus.A     = a;
    @(negedge clk);
    bus.q_req = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.status !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.status !== 1'b1) begin errors++; $display("FAIL %s_ready status=%0b after %0d cycles, want 1", tag, bus.status, n); end
    checks++; if (n < MINES) begin errors++; $display("FAIL %s_latency ready after %0d cycles, want >= %0d", tag, n, MINES); end
    checks++; if (bus.placed !== 8'(MINES)) begin errors++; $display("FAIL %s_placed got %0d want %0d", tag, bus.placed, MINES); end
  endtask

  task automatic sweep_board(input string tag);
    int mines = 0, vld = 0, bad = 0;
    for (int a = 0; a < 256; a++) begin
      query(8'(a));
      mines += int'(bus.is_mine);
      vld   += int'(bus.valid);
      if (bus.mine_cnt > 4'd8) bad++;
`ifdef SAFE_FIRST_EN
      if (a == 8'h77) begin
        checks++; if (bus.is_mine !== 1'b0) begin errors++; $display("FAIL %s_safe_cell is_mine=%0b want 0", tag, bus.is_mine); end
      end
`endif
    end
    checks++; if (mines != MINES) begin errors++; $display("FAIL %s_popcount got %0d want %0d", tag, mines, MINES); end
    checks++; if (vld != 256) begin errors++; $display("FAIL %s_valid_pulses got %0d want 256", tag, vld); end
    checks++; if (bad != 0) begin errors++; $display("FAIL %s_cnt_range cells_over_8=%0d want 0", tag, bad); end
  endtask

  task automatic test_reset();
    bus.initcue = 1'b0;
    bus.q_req   = 1'b0;
    bus.A       = 8'h00;
`ifdef SAFE_FIRST_EN
    bus.safe_addr = 8'h77;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.status !== 1'b0)   begin errors++; $display("FAIL reset_status got %0b want 0", bus.status); end
    checks++; if (bus.placed !== 8'd0)   begin errors++; $display("FAIL reset_placed got %0d want 0", bus.placed); end
    checks++; if (bus.valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got %0b want 0", bus.valid); end
    checks++; if (bus.is_mine !== 1'b0)  begin errors++; $display("FAIL reset_is_mine got %0b want 0", bus.is_mine); end
    checks++; if (bus.mine_cnt !== 4'd0) begin errors++; $display("FAIL reset_mine_cnt got %0d want 0", bus.mine_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_query_idle();
    query(8'h55);
    checks++; if (bus.valid !== 1'b1)    begin errors++; $display("FAIL idle_valid got %0b want 1", bus.valid); end
    checks++; if (bus.is_mine !== 1'b0)  begin errors++; $display("FAIL idle_is_mine got %0b want 0", bus.is_mine); end
    checks++; if (bus.mine_cnt !== 4'd0) begin errors++; $display("FAIL idle_mine_cnt got %0d want 0", bus.mine_cnt); end
    @(negedge clk);
    checks++; if (bus.valid !== 1'b0)    begin errors++; $display("FAIL idle_valid_pulse got %0b want 0", bus.valid); end
  endtask

  task automatic test_place();
    @(negedge clk);
    bus.initcue = 1'b1;
    wait_ready("place");
    bus.initcue = 1'b0;
    sweep_board("place");
  endtask

  task automatic test_neighbours();
    logic [7:0] addrs [4] = '{8'h11, 8'h00, 8'h01, 8'hFF};
    logic       exp_m [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp_c [4] = '{4'd3, 4'd2, 4'd2, 4'd0};
    tb_bm = '0;
    tb_bm[8'h00] = 1'b1;
    tb_bm[8'h01] = 1'b1;
    tb_bm[8'h10] = 1'b1;
    @(negedge clk);
    force dut.r_bitmap = tb_bm;
    for (int i = 0; i < 4; i++) begin
      query(addrs[i]);
      checks++; if (bus.valid !== 1'b1 || bus.is_mine !== exp_m[i] || bus.mine_cnt !== exp_c[i]) begin
        errors++; $display("FAIL nbr_%02h got valid=%0b mine=%0b cnt=%0d want 1/%0b/%0d", addrs[i], bus.valid, bus.is_mine, bus.mine_cnt, exp_m[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [7:0] addrs [6] = '{8'h30, 8'h3E, 8'h3F, 8'h40, 8'h4E, 8'h2F};
    logic       exp_m [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] exp_c [6] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1};
    @(negedge clk);
    tb_bm = '0;
    tb_bm[8'h3F] = 1'b1;
    force dut.r_bitmap = tb_bm;
    for (int i = 0; i < 6; i++) begin
      query(addrs[i]);
      checks++; if (bus.is_mine !== exp_m[i] || bus.mine_cnt !== exp_c[i]) begin
        errors++; $display("FAIL edge_%02h got mine=%0b cnt=%0d want %0b/%0d", addrs[i], bus.is_mine, bus.mine_cnt, exp_m[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] addrs [4] = '{8'h11, 8'h00, 8'h22, 8'h3F};
    logic       exp_m [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_c [4] = '{4'd3, 4'd2, 4'd0, 4'd0};
    @(negedge clk);
    tb_bm = '0;
    tb_bm[8'h00] = 1'b1;
    tb_bm[8'h01] = 1'b1;
    tb_bm[8'h10] = 1'b1;
    force dut.r_bitmap = tb_bm;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (bus.valid !== 1'b1 || bus.is_mine !== exp_m[i-1] || bus.mine_cnt !== exp_c[i-1]) begin
          errors++; $display("FAIL b2b_%0d got valid=%0b mine=%0b cnt=%0d want 1/%0b/%0d", i-1, bus.valid, bus.is_mine, bus.mine_cnt, exp_m[i-1], exp_c[i-1]);
        end
      end
      bus.q_req = (i < 4);
      if (i < 4) bus.A = addrs[i];
    end
    @(negedge clk);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL b2b_idle valid=%0b want 0", bus.valid); end
  endtask

  task automatic test_clear_query();
    @(negedge clk);
    bus.initcue = 1'b1;
    @(negedge clk);
    bus.q_req = 1'b1;
    bus.A     = 8'h11;
    @(negedge clk);
    bus.q_req = 1'b0;
    checks++; if (bus.valid !== 1'b1 || bus.mine_cnt !== 4'd3 || bus.is_mine !== 1'b0) begin
      errors++; $display("FAIL clear_query got valid=%0b mine=%0b cnt=%0d want 1/0/3", bus.valid, bus.is_mine, bus.mine_cnt);
    end
    checks++; if (bus.status !== 1'b0) begin errors++; $display("FAIL clear_status got %0b want 0", bus.status); end
    checks++; if (bus.placed !== 8'd0) begin errors++; $display("FAIL clear_placed got %0d want 0", bus.placed); end
    rst_n = 1'b0;
    bus.initcue = 1'b0;
    @(negedge clk);
    release dut.r_bitmap;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_restart_mid_place();
    int n = 0;
    @(negedge clk);
    bus.initcue = 1'b1;
    @(negedge clk);
    bus.initcue = 1'b0;
    while (bus.placed !== 8'd10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.placed !== 8'd10) begin errors++; $display("FAIL restart_reach10 placed=%0d want 10", bus.placed); end
    bus.initcue = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.placed !== 8'd0) begin errors++; $display("FAIL restart_placed got %0d want 0", bus.placed); end
    checks++; if (bus.status !== 1'b0) begin errors++; $display("FAIL restart_status got %0b want 0", bus.status); end
    wait_ready("restart");
    bus.initcue = 1'b0;
    sweep_board("restart");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.initcue = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.placed !== 8'd0) begin errors++; $display("FAIL areset_placed got %0d want 0", bus.placed); end
    checks++; if (bus.status !== 1'b0) begin errors++; $display("FAIL areset_status got %0b want 0", bus.status); end
    bus.initcue = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (bus.placed !== 8'd0) begin errors++; $display("FAIL areset_idle_placed got %0d want 0", bus.placed); end
    query(8'h00);
    checks++; if (bus.valid !== 1'b1 || bus.is_mine !== 1'b0 || bus.mine_cnt !== 4'd0) begin
      errors++; $display("FAIL areset_query got valid=%0b mine=%0b cnt=%0d want 1/0/0", bus.valid, bus.is_mine, bus.mine_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_query_idle();
    test_place();
    test_neighbours();
    test_boundary();
    test_back_to_back();
    test_clear_query();
    test_restart_mid_place();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
